// File: rtl/pdm_decoder.sv
// PDM-to-PCM decoder: 2nd-order CIC decimator (R = 2^DECIM_LOG2, M = 1) with saturating output.
// Optional macro PDM_DECODER_SYNC_EN adds a 2-flop input synchroniser on pdm_in and in_en.
module pdm_decoder #(
  parameter int WIDTH      = 10,
  parameter int DECIM_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic             pdm_in,
  output logic [WIDTH-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             settled
);

  localparam int FS = 2 * DECIM_LOG2;
  localparam int W  = FS + 1;
  localparam logic [DECIM_LOG2-1:0] PH_ONE  = {{(DECIM_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DECIM_LOG2-1:0] PH_LAST = {DECIM_LOG2{1'b1}};

  // Clamp the full-scale value N^2 to N^2-1 and keep the top WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_scale(input logic [W-1:0] c);
    logic [FS-1:0] y;
    if (c[W-1]) begin
      y = {FS{1'b1}};
    end else begin
      y = c[FS-1:0];
    end
    return y[FS-1 -: WIDTH];
  endfunction

  logic en_s;
  logic bit_s;

`ifdef PDM_DECODER_SYNC_EN
  logic [1:0] en_sync_q;
  logic [1:0] bit_sync_q;

  // Two-flop synchroniser for asynchronous PDM sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q  <= 2'b00;
      bit_sync_q <= 2'b00;
    end else begin
      en_sync_q  <= {en_sync_q[0], in_en};
      bit_sync_q <= {bit_sync_q[0], pdm_in};
    end
  end

  assign en_s  = en_sync_q[1];
  assign bit_s = bit_sync_q[1];
`else
  assign en_s  = in_en;
  assign bit_s = pdm_in;
`endif

  logic [W-1:0]          i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0]          d1_q, d1_d, d2_q, d2_d;
  logic [W-1:0]          i1_nx_s, i2_nx_s, c1_s, c2_s;
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [1:0]            prime_q, prime_d;
  logic [WIDTH-1:0]      pcm_q, pcm_d;
  logic                  valid_q, valid_d;
  logic                  settled_q, settled_d;
  logic                  dec_s;

  // Integrator, comb and output next-state logic; comb arithmetic wraps modulo 2^W by design.
  always_comb begin
    i1_nx_s   = i1_q + {{(W-1){1'b0}}, bit_s};
    i2_nx_s   = i2_q + i1_nx_s;
    c1_s      = i2_nx_s - d1_q;
    c2_s      = c1_s - d2_q;
    dec_s     = en_s && (phase_q == PH_LAST);
    i1_d      = i1_q;
    i2_d      = i2_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    phase_d   = phase_q;
    prime_d   = prime_q;
    pcm_d     = pcm_q;
    valid_d   = 1'b0;
    settled_d = settled_q;
    if (en_s) begin
      i1_d    = i1_nx_s;
      i2_d    = i2_nx_s;
      phase_d = phase_q + PH_ONE;
    end else begin
      phase_d = phase_q;
    end
    if (dec_s) begin
      d1_d = i2_nx_s;
      d2_d = c1_s;
      // The first two events only fill the comb delays.
      if (prime_q != 2'd2) begin
        prime_d = prime_q + 2'd1;
      end else begin
        pcm_d     = sat_scale(c2_s);
        valid_d   = 1'b1;
        settled_d = 1'b1;
      end
    end else begin
      prime_d = prime_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q      <= {W{1'b0}};
      i2_q      <= {W{1'b0}};
      d1_q      <= {W{1'b0}};
      d2_q      <= {W{1'b0}};
      phase_q   <= {DECIM_LOG2{1'b0}};
      prime_q   <= 2'd0;
      pcm_q     <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      phase_q   <= phase_d;
      prime_q   <= prime_d;
      pcm_q     <= pcm_d;
      valid_q   <= valid_d;
      settled_q <= settled_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;
  assign settled   = settled_q;

endmodule
